// File: rtl/memory_responder.sv
// Main-memory model answering cache miss/fill requests.
// Writes land on accept; reads return in issue order after LATENCY cycles.
module memory_responder #(
    parameter int LATENCY    = 4,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [15:0]           data_in,
    output logic [15:0]           data_out,
    output logic                  data_valid,
    output logic                  busy
);

    localparam int WORDS = 2 ** (ADDR_WIDTH - 1);

    logic [15:0]           mem [WORDS];
    logic [ADDR_WIDTH-2:0] idx;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  unused_bit;

    logic [LATENCY-1:0]    pipe_vld;
    logic [15:0]           pipe_dat [LATENCY];
    logic [15:0]           last_dat;

    assign idx        = addr[ADDR_WIDTH-1:1];
    assign unused_bit = addr[0];
    assign rd_acc     = rst & enable & ~wr;
    assign wr_acc     = rst & enable & wr;

    // Storage survives reset, so it sits outside the reset domain.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[idx] <= data_in;
        end
    end

    // Read data is captured at issue so later writes cannot alter it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld <= '0;
            last_dat <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
            pipe_vld[0] <= rd_acc;
            if (rd_acc) begin
                pipe_dat[0] <= mem[idx];
            end
            if (pipe_vld[LATENCY-1]) begin
                last_dat <= pipe_dat[LATENCY-1];
            end
        end
    end

    assign data_valid = pipe_vld[LATENCY-1];
    assign data_out   = data_valid ? pipe_dat[LATENCY-1] : last_dat;
    assign busy       = |pipe_vld;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: driver queues expected reads,
// a negedge monitor checks data, arrival cycle, busy and reset state.
module tb_memory_responder;

    localparam int LAT = 4;
    localparam int AW  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [15:0]   data_in = '0;
    logic [15:0]   data_out;
    logic          data_valid;
    logic          busy;

    typedef struct {
        logic [15:0] data;
        int          iss;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    memory_responder #(.LATENCY(LAT), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h",
                     name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   busy_exp;
        if (!rst) begin
            chk("rst_valid", int'(data_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_data", int'(data_out), 0);
        end else begin
            busy_exp = 1'b0;
            foreach (q[i]) begin
                if (q[i].iss < cyc && q[i].due >= cyc) busy_exp = 1'b1;
            end
            chk("busy", int'(busy), int'(busy_exp));
            if (data_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rd_data", int'(data_out), int'(e.data));
                    chk("rd_cycle", cyc, e.due);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk("missing_valid", 0, 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic do_wr(input logic [AW-1:0] a, input logic [15:0] d);
        enable = 1'b1; wr = 1'b1; addr = a; data_in = d;
        step();
    endtask

    task automatic do_rd(input logic [AW-1:0] a, input logic [15:0] d);
        exp_t e;
        enable = 1'b1; wr = 1'b0; addr = a; data_in = 16'hDEAD;
        e.data = d; e.iss = cyc; e.due = cyc + LAT;
        q.push_back(e);
        step();
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        // Reset held with a read strobe asserted: must be ignored
        #1;
        rst = 1'b0; enable = 1'b1; wr = 1'b0; addr = 16'h0010;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; enable = 1'b0;
        idle(8);

        // Write then read, latency and busy window
        do_wr(16'h0010, 16'h1234);
        do_rd(16'h0010, 16'h1234);
        idle(6);

        // Cache-fill burst
        for (int i = 0; i < 8; i++)
            do_wr(AW'(16'h0100 + 2 * i), 16'(16'hA000 + i));
        for (int i = 0; i < 8; i++)
            do_rd(AW'(16'h0100 + 2 * i), 16'(16'hA000 + i));
        idle(6);

        // In-flight hazard
        do_wr(16'h0020, 16'h5555);
        do_rd(16'h0020, 16'h5555);
        do_wr(16'h0020, 16'hBEEF);
        do_rd(16'h0020, 16'hBEEF);
        idle(6);

        // Bit-0 alias
        do_wr(16'h0031, 16'h00FF);
        do_rd(16'h0030, 16'h00FF);
        do_rd(16'h0031, 16'h00FF);
        idle(6);

        // Reset mid-flight
        do_rd(16'h0100, 16'hA000);
        do_rd(16'h0102, 16'hA001);
        idle(1);
        rst = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(8);
        do_rd(16'h0010, 16'h1234);
        do_rd(16'h0020, 16'hBEEF);

        for (int i = 0; i < 50 && q.size() > 0; i++) idle(1);
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Main-memory model: the responder end of the cache miss/fill memory interface.
- Accepts single-cycle read and write commands from the cache fill FSM.
- Writes complete in the cycle they are accepted.
- Reads are pipelined: each returns data with a one-cycle valid pulse a fixed LATENCY cycles after issue, in issue order, one new request per cycle.
- Serves as the backing store for the I-cache and D-cache in the 5-stage pipeline.

Parameters:
- LATENCY, 4, cycles from read acceptance edge to data_valid; legal range 1..8.
- ADDR_WIDTH, 16, byte-address width; storage holds 2^(ADDR_WIDTH-1) 16-bit words.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- enable  input  1  request strobe; one request accepted per cycle when high
- wr  input  1  qualifies enable: 1 = write, 0 = read
- addr  input  ADDR_WIDTH  byte address; addr[0] ignored, word index = addr[ADDR_WIDTH-1:1]
- data_in  input  16  write data
- data_out  output  16  read data, meaningful only while data_valid=1
- data_valid  output  1  one-cycle pulse per completed read
- busy  output  1  high while any read is in flight (pipeline non-empty)

Behaviour:
- Reset (rst=0, async): in-flight read pipeline cleared, data_valid=0, data_out=16'h0000, busy=0.
  - Storage contents are NOT cleared by reset.
  - Requests presented while rst=0 are ignored.
- Write: on rising edge with enable=1, wr=1, mem[addr[ADDR_WIDTH-1:1]] <= data_in.
  - Visible to any read accepted on a later edge.
  - No response pulse; data_valid unaffected.
- Read acceptance: on rising edge with enable=1, wr=0, the word is sampled from storage at that edge and enters a LATENCY-deep shift pipeline (valid bit + 16-bit data per stage).
  - Because data is sampled at issue, a later write to the same address does not alter a read already in flight.
- Read response: a read accepted at edge T drives data_valid=1 with its data on data_out in the cycle after edge T+LATENCY-1, i.e. valid exactly LATENCY cycles after the request cycle.
  - data_valid falls after one cycle unless the next pipelined read follows.
- Ordering and throughput:
  - Responses return strictly in issue order.
  - Back-to-back reads on N consecutive cycles produce N consecutive data_valid cycles.
  - No backpressure: the requester must accept every response.
- Mixed traffic: reads and writes may be interleaved cycle by cycle.
  - A write never delays or reorders in-flight reads.
  - A read and a write cannot occur in the same cycle (single command port).
- data_out when data_valid=0: holds the last returned value (0 after reset). Verification must not check it.
- busy = OR of all pipeline valid bits. It rises on the edge a read is accepted and falls on the edge the last in-flight read retires.
- enable=0: wr, addr and data_in are don't-care and have no effect.
- Reset mid-operation: all in-flight reads are discarded, with no data_valid pulse for them after reset release. Writes accepted before reset assertion persist.
- Address wrap: none. Every addr in the ADDR_WIDTH range maps to a unique word; addresses differing only in bit 0 alias the same word.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with enable=1, wr=0 -> data_valid=0, busy=0, data_out=16'h0000 throughout; no pulse after release.
2. Write/read latency: write 16'h1234 to 16'h0010 at cycle 0, read 16'h0010 at cycle 1 -> data_valid=1, data_out=16'h1234 only in cycle 5 (LATENCY=4); busy high cycles 2-5.
3. Cache-fill burst: preload 16'hA000+i at 16'h0100+2i (i=0..7), then 8 consecutive reads 16'h0100..16'h010E -> 8 consecutive data_valid cycles returning 16'hA000..16'hA007 in order.
4. In-flight hazard: mem[16'h0020]=16'h5555; read 16'h0020, next cycle write 16'hBEEF to 16'h0020, then read again -> first response 16'h5555, second 16'hBEEF.
5. Bit-0 alias: write 16'h00FF to 16'h0031, read 16'h0030 -> returns 16'h00FF.
6. Reset mid-flight: issue reads on 2 consecutive cycles, assert rst 2 cycles later -> no data_valid pulse at any time afterwards, busy=0 immediately; a subsequent read of a previously written address returns the stored value.
